// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite-DMA controller and bus arbiter between the k6502 core
// and the shared system bus. A CPU write of XX to DMA_REG_ADDR halts the CPU,
// copies XX00..XXFF to DEST_ADDR one byte at a time (read then write), then
// hands the bus back to the CPU.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cpu_a/cpu_dout/cpu_rw   CPU address, write data, rw (1=read)
//   bus_din                 system bus read data
//   bus_a/bus_dout/bus_rw   system bus address, write data, rw
//   cpu_rdy                 1=CPU may run, 0=CPU halted
//   busy                    transfer in progress
//   done                    one-cycle pulse after the last write
//
// Optional: define OAM_DMA_DEBUG_EN to add debug_state[2:0] and debug_idx[7:0].
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR    = 16'h2004,
   parameter int          XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_din,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_dout,
   output logic        bus_rw,
   output logic        cpu_rdy,
   output logic        busy,
   output logic        done
`ifdef OAM_DMA_DEBUG_EN
  ,output logic [2:0]  debug_state,
   output logic [7:0]  debug_idx
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   // Index is 8 bits wide; a 256-byte transfer ends at 8'hFF.
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state, state_nxt;
   logic [7:0] page, idx, latch;
   logic       parity;
   logic       trig, last;

   assign trig = (cpu_rw == 1'b0) && (cpu_a == DMA_REG_ADDR);
   assign last = (idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         page   <= 8'h00;
         idx    <= 8'h00;
         parity <= 1'b0;
         latch  <= 8'h00;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         parity <= ~parity;
         done   <= (state == S_WRITE) && last;
         case (state)
            S_IDLE:  if (trig) begin
                        page <= cpu_dout;
                        idx  <= 8'h00;
                     end
            S_READ:  latch <= bus_din;
            S_WRITE: if (!last) idx <= idx + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      bus_a     = cpu_a;
      bus_dout  = cpu_dout;
      bus_rw    = cpu_rw;
      cpu_rdy   = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            cpu_rdy = 1'b1;
            busy    = 1'b0;
            // The triggering CPU write itself still goes out on the bus.
            if (trig) state_nxt = S_HALT;
         end
         S_HALT: begin
            bus_rw = 1'b1;
            // Reads must land on parity=0 cycles; skip ALIGN if already there.
            state_nxt = parity ? S_READ : S_ALIGN;
         end
         S_ALIGN: begin
            bus_rw    = 1'b1;
            state_nxt = S_READ;
         end
         S_READ: begin
            bus_a     = {page, idx};
            bus_rw    = 1'b1;
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            bus_a     = DEST_ADDR;
            bus_rw    = 1'b0;
            bus_dout  = latch;
            state_nxt = last ? S_IDLE : S_READ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef OAM_DMA_DEBUG_EN
   assign debug_state = state;
   assign debug_idx   = idx;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl. A byte-array memory backs bus_din;
// expected data/addresses and stall lengths come from the transfer rules
// (256 reads of page*256+i, each copied to 16'h2004; 513/514-cycle stall
// chosen by the parity of the trigger edge count).
module tb_oam_dma_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_rw;
   logic [7:0]  bus_din;
   logic [15:0] bus_a;
   logic [7:0]  bus_dout;
   logic        bus_rw;
   logic        cpu_rdy, busy, done;

   oam_dma_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
      .cpu_rw(cpu_rw), .bus_din(bus_din), .bus_a(bus_a), .bus_dout(bus_dout),
      .bus_rw(bus_rw), .cpu_rdy(cpu_rdy), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [65536];
   assign bus_din = mem[bus_a];

   int checks = 0;
   int errors = 0;

   // Posedges since reset release; parity during the cycle after edge k is k&1.
   int edge_cnt;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;

   // Bus monitor: DMA writes (data + address of the preceding read cycle),
   // completed stall lengths, and done pulses.
   logic [7:0]  wr_d[$];
   logic [15:0] wr_a[$];
   int          stall_q[$];
   int          stall_run = 0;
   int          done_cnt = 0;
   logic [15:0] prev_a = 16'h0;
   always @(negedge clk) begin
      if (busy && !bus_rw) begin
         wr_d.push_back(bus_dout);
         wr_a.push_back(prev_a);
      end
      prev_a = bus_a;
      if (!cpu_rdy) stall_run++;
      else if (stall_run != 0) begin
         stall_q.push_back(stall_run);
         stall_run = 0;
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Trigger a transfer of page pg. par: 0/1 forces HALT parity, 2 = any.
   task automatic start(input logic [7:0] pg, input int par, output int exp_stall);
      @(negedge clk);
      if (par != 2 && (((edge_cnt + 1) & 1) != par)) @(negedge clk);
      cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = pg;
      #1;
      chk("cpu_wr_pass_a",  32'(bus_a),    32'h4014);
      chk("cpu_wr_pass_rw", 32'(bus_rw),   32'h0);
      chk("cpu_wr_pass_d",  32'(bus_dout), 32'(pg));
      @(posedge clk); #1;
      exp_stall = ((edge_cnt & 1) != 0) ? 513 : 514;
      cpu_rw = 1'b1; cpu_a = 16'($urandom_range(0, 16'h1FFF)); cpu_dout = 8'($urandom);
   endtask

   task automatic wait_done();
      logic ok = 1'b0;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk); #1;
         if (done) begin ok = 1'b1; break; end
      end
      chk("done_seen", 32'(ok), 32'h1);
   endtask

   task automatic verify(input string tag, input logic [7:0] pg, input int w0);
      for (int i = 0; i < 256; i++) begin
         logic [15:0] src = {pg, 8'(i)};
         if (w0 + i >= wr_d.size()) begin
            chk({tag, "_missing"}, 32'(w0 + i), 32'(wr_d.size()));
            break;
         end
         chk({tag, "_data"}, 32'(wr_d[w0 + i]), 32'(mem[src]));
         chk({tag, "_addr"}, 32'(wr_a[w0 + i]), 32'(src));
      end
   endtask

   initial begin
      int w0, s0, d0, es, es2;
      logic [7:0] pg, pg2;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

      // Reset with random CPU activity.
      rst_n = 1'b0; cpu_a = 16'h0; cpu_dout = 8'h0; cpu_rw = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         cpu_a = 16'($urandom); cpu_dout = 8'($urandom); cpu_rw = 1'($urandom);
         @(negedge clk);
         chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
         chk("rst_busy",    32'(busy),    32'h0);
         chk("rst_done",    32'(done),    32'h0);
         chk("rst_bus_a",   32'(bus_a),   32'(cpu_a));
      end
      cpu_rw = 1'b1;
      rst_n = 1'b1;

      // Page 02, parity 0 at HALT: 514-cycle stall.
      w0 = wr_d.size(); s0 = stall_q.size(); d0 = done_cnt;
      start(8'h02, 0, es);
      #1 chk("halt_cpu_rdy", 32'(cpu_rdy), 32'h0);
      chk("halt_busy", 32'(busy), 32'h1);
      wait_done();
      repeat (3) @(negedge clk);
      chk("p0_nwr", 32'(wr_d.size() - w0), 32'd256);
      verify("p0", 8'h02, w0);
      chk("p0_first_d", 32'(wr_d[w0]), 32'h5A);
      chk("p0_stall", 32'(stall_q[s0]), 32'd514);
      chk("p0_stall_model", 32'(es), 32'd514);
      chk("p0_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Page 02, parity 1 at HALT: 513-cycle stall.
      w0 = wr_d.size(); s0 = stall_q.size(); d0 = done_cnt;
      start(8'h02, 1, es);
      wait_done();
      repeat (3) @(negedge clk);
      chk("p1_nwr", 32'(wr_d.size() - w0), 32'd256);
      verify("p1", 8'h02, w0);
      chk("p1_stall", 32'(stall_q[s0]), 32'd513);
      chk("p1_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Page FF with an ignored trigger write mid-transfer.
      w0 = wr_d.size(); s0 = stall_q.size(); d0 = done_cnt;
      start(8'hFF, 2, es);
      repeat (40) @(negedge clk);
      cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h33;
      @(negedge clk);
      cpu_rw = 1'b1; cpu_a = 16'h0123;
      wait_done();
      repeat (3) @(negedge clk);
      chk("pff_nwr", 32'(wr_d.size() - w0), 32'd256);
      verify("pff", 8'hFF, w0);
      chk("pff_stall", 32'(stall_q[s0]), 32'(es));
      chk("pff_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Reset after 100 writes, then a fresh full transfer.
      pg = 8'($urandom);
      w0 = wr_d.size(); d0 = done_cnt;
      start(pg, 2, es);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk); #1;
         if (wr_d.size() - w0 == 100 && !bus_rw) break;
      end
      chk("mid_nwr_before", 32'(wr_d.size() - w0), 32'd100);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_rw",  32'(bus_rw),  32'h1);
      chk("mid_rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
      chk("mid_rst_busy",    32'(busy),    32'h0);
      repeat (3) begin
         @(negedge clk); #1;
         chk("mid_rst_done", 32'(done), 32'h0);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_nwr_after", 32'(wr_d.size() - w0), 32'd100);
      chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
      w0 = wr_d.size(); s0 = stall_q.size();
      start(pg, 2, es);
      wait_done();
      repeat (3) @(negedge clk);
      chk("post_rst_nwr", 32'(wr_d.size() - w0), 32'd256);
      verify("post_rst", pg, w0);
      chk("post_rst_stall", 32'(stall_q[s0]), 32'(es));

      // Back-to-back: second trigger in the done cycle.
      pg = 8'($urandom); pg2 = 8'($urandom);
      w0 = wr_d.size(); s0 = stall_q.size(); d0 = done_cnt;
      start(pg, 2, es);
      wait_done();
      cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = pg2;
      @(posedge clk); #1;
      es2 = ((edge_cnt & 1) != 0) ? 513 : 514;
      cpu_rw = 1'b1; cpu_a = 16'h0456;
      chk("b2b_halted", 32'(cpu_rdy), 32'h0);
      wait_done();
      repeat (3) @(negedge clk);
      chk("b2b_nwr", 32'(wr_d.size() - w0), 32'd512);
      verify("b2b_a", pg, w0);
      verify("b2b_b", pg2, w0 + 256);
      chk("b2b_stall_a", 32'(stall_q[s0]), 32'(es));
      chk("b2b_stall_b", 32'(stall_q[s0 + 1]), 32'(es2));
      chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
